// File: rtl/gate_bank_checker.sv
// gate_bank_checker: self-test engine for a 7-bit basic-gate bank.
// Walks the four {a,b} vectors 00,01,10,11. Each vector is held for
// SETTLE_CYCLES cycles and then checked for one cycle against the known
// gate truth table. Mismatches are accumulated into a pass/fail summary.
// Optional feature macro: GATE_CHECK_STOP_ON_FAIL_EN. When defined, the
// first failing vector ends the run.
//
// Handshake: start is a request that is accepted only while busy=0, which
// covers both IDLE and DONE. It is ignored while busy=1. Once a run is
// accepted, done=1 marks results valid. Results stay valid until the next
// accepted start or rst.
module gate_bank_checker #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] z_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] fail_mask,
  output logic [1:0] first_fail_idx,
  output logic [2:0] err_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [1:0] idx, idx_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       done_nxt, pass_nxt;
  logic [6:0] fail_mask_nxt;
  logic [1:0] first_fail_idx_nxt;
  logic [2:0] err_count_nxt;
  logic [6:0] exp_z, mism, mask_acc;

  // The vector under test is the stimulus itself.
  assign a_out = idx[1];
  assign b_out = idx[0];
  assign busy  = (state == APPLY) || (state == CHECK);

  // Golden response of an ideal gate bank for each {a,b}.
  always_comb begin
    exp_z = 7'h6C;
    case (idx)
      2'b00:   exp_z = 7'h6C;
      2'b01:   exp_z = 7'h56;
      2'b10:   exp_z = 7'h16;
      default: exp_z = 7'h23;
    endcase
  end

  assign mism     = z_in ^ exp_z;
  assign mask_acc = fail_mask | mism;

  // Next-state and result updates; everything holds unless a state acts.
  always_comb begin
    state_nxt          = state;
    idx_nxt            = idx;
    cnt_nxt            = cnt;
    done_nxt           = done;
    pass_nxt           = pass;
    fail_mask_nxt      = fail_mask;
    first_fail_idx_nxt = first_fail_idx;
    err_count_nxt      = err_count;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          idx_nxt            = 2'b00;
          cnt_nxt            = 4'd0;
          fail_mask_nxt      = 7'h00;
          err_count_nxt      = 3'd0;
          first_fail_idx_nxt = 2'b00;
          pass_nxt           = 1'b0;
          done_nxt           = 1'b0;
          state_nxt          = APPLY;
        end
      end
      APPLY: begin
        if (cnt == SETTLE_LAST) begin
          state_nxt = CHECK;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      CHECK: begin
        fail_mask_nxt = mask_acc;
        if (mism != 7'h00) begin
          err_count_nxt = err_count + 3'd1;
          if (err_count == 3'd0) begin
            first_fail_idx_nxt = idx;
          end
        end
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
        if ((idx == 2'b11) || (mism != 7'h00)) begin
`else
        if (idx == 2'b11) begin
`endif
          state_nxt = DONE;
          done_nxt  = 1'b1;
          pass_nxt  = (mask_acc == 7'h00);
        end else begin
          idx_nxt   = idx + 2'd1;
          cnt_nxt   = 4'd0;
          state_nxt = APPLY;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and result registers with synchronous reset that discards any partial run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= 2'b00;
      cnt            <= 4'd0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_mask      <= 7'h00;
      first_fail_idx <= 2'b00;
      err_count      <= 3'd0;
    end else begin
      state          <= state_nxt;
      idx            <= idx_nxt;
      cnt            <= cnt_nxt;
      done           <= done_nxt;
      pass           <= pass_nxt;
      fail_mask      <= fail_mask_nxt;
      first_fail_idx <= first_fail_idx_nxt;
      err_count      <= err_count_nxt;
    end
  end

endmodule

// File: tb/tb_gate_bank_checker.sv
// Bench for gate_bank_checker: two instances (SETTLE_CYCLES=1 and 3) with
// bench-side gate bank models. A reference model, built from the gate
// equations, predicts every output on every cycle.
module tb_gate_bank_checker;

  localparam int S0 = 1;
  localparam int S1 = 3;

  logic       clk;
  logic       rst;
  logic       start_i [2];
  logic [6:0] z_i     [2];
  logic       a_o     [2];
  logic       b_o     [2];
  logic       busy_o  [2];
  logic       done_o  [2];
  logic       pass_o  [2];
  logic [6:0] mask_o  [2];
  logic [1:0] first_o [2];
  logic [2:0] err_o   [2];

  int  mode [2];
  logic glitch;
  logic chk_en;
  int  n_checks;
  int  n_fail;

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  gate_bank_checker #(.SETTLE_CYCLES(S0)) dut0 (
    .clk(clk), .rst(rst), .start(start_i[0]), .z_in(z_i[0]),
    .a_out(a_o[0]), .b_out(b_o[0]), .busy(busy_o[0]), .done(done_o[0]),
    .pass(pass_o[0]), .fail_mask(mask_o[0]), .first_fail_idx(first_o[0]),
    .err_count(err_o[0])
  );

  gate_bank_checker #(.SETTLE_CYCLES(S1)) dut1 (
    .clk(clk), .rst(rst), .start(start_i[1]), .z_in(z_i[1]),
    .a_out(a_o[1]), .b_out(b_o[1]), .busy(busy_o[1]), .done(done_o[1]),
    .pass(pass_o[1]), .fail_mask(mask_o[1]), .first_fail_idx(first_o[1]),
    .err_count(err_o[1])
  );

  // Ideal gates: {NOT a, XNOR, XOR, NOR, NAND, OR, AND}
  function automatic logic [6:0] ideal_z(input logic a, input logic b);
    return {~a, ~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};
  endfunction

  // Bank personalities: 0 ideal, 1 XOR stuck-at-0, 2 all inverted, 3 ideal (glitch handled outside)
  function automatic logic [6:0] bank_z(input int md, input logic a, input logic b);
    logic [6:0] z;
    z = ideal_z(a, b);
    case (md)
      1:       z = z & 7'h6F;
      2:       z = ~z;
      default: z = z;
    endcase
    return z;
  endfunction

  always_comb begin
    z_i[0] = bank_z(mode[0], a_o[0], b_o[0]);
    z_i[1] = glitch ? 7'h00 : bank_z(mode[1], a_o[1], b_o[1]);
  end

  // Outcome of a whole run against a given bank personality
  typedef struct packed {
    logic [6:0] mask;
    logic [2:0] cnt;
    logic [1:0] first;
    int         nv;
  } res_t;

  function automatic res_t model_run(input int md);
    res_t r;
    logic [6:0] m;
    logic [1:0] v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      v = 2'(i);
      m = bank_z(md, v[1], v[0]) ^ ideal_z(v[1], v[0]);
      r.nv = r.nv + 1;
      if (m != 7'h00) begin
        if (r.cnt == 3'd0) r.first = v;
        r.cnt = r.cnt + 3'd1;
      end
      r.mask = r.mask | m;
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
      if (m != 7'h00) break;
`endif
    end
    return r;
  endfunction

  // Reference model timeline: k counts edges since the accepted start edge
  logic m_started [2];
  int   m_k       [2];
  int   m_len     [2];
  res_t m_res     [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_started[d] <= 1'b0;
        m_k[d]       <= 0;
        m_len[d]     <= 0;
        m_res[d]     <= '0;
      end else if (start_i[d] && !(m_started[d] && (m_k[d] < m_len[d]))) begin
        m_started[d] <= 1'b1;
        m_k[d]       <= 0;
        m_res[d]     <= model_run(mode[d]);
        m_len[d]     <= model_run(mode[d]).nv * (((d == 0) ? S0 : S1) + 1);
      end else if (m_started[d] && (m_k[d] < m_len[d])) begin
        m_k[d] <= m_k[d] + 1;
      end
    end
  end

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
    end
  endtask

  // Scoreboard compare: every cycle, both instances, against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        int         sp;
        logic       e_busy;
        logic [1:0] e_ab;
        sp = (d == 0) ? S0 : S1;
        if (!m_started[d]) begin
          chk("idle_busy", d, 32'(busy_o[d]), 0);
          chk("idle_done", d, 32'(done_o[d]), 0);
          chk("idle_ab", d, 32'({a_o[d], b_o[d]}), 0);
          chk("idle_pass", d, 32'(pass_o[d]), 0);
          chk("idle_mask", d, 32'(mask_o[d]), 0);
          chk("idle_err", d, 32'(err_o[d]), 0);
          chk("idle_first", d, 32'(first_o[d]), 0);
        end else begin
          e_busy = (m_k[d] < m_len[d]);
          e_ab   = e_busy ? 2'(m_k[d] / (sp + 1)) : 2'(m_res[d].nv - 1);
          chk("busy", d, 32'(busy_o[d]), 32'(e_busy));
          chk("done", d, 32'(done_o[d]), 32'(!e_busy));
          chk("ab", d, 32'({a_o[d], b_o[d]}), 32'(e_ab));
          if (!e_busy) begin
            chk("pass", d, 32'(pass_o[d]), 32'(m_res[d].cnt == 3'd0));
            chk("mask", d, 32'(mask_o[d]), 32'(m_res[d].mask));
            chk("err", d, 32'(err_o[d]), 32'(m_res[d].cnt));
            chk("first", d, 32'(first_o[d]), 32'(m_res[d].first));
          end
        end
      end
    end
  end

  // Driver: pulse start, optionally poke start while busy, wait for done with a bound
  task automatic run(input int d, input int exp_lat, input bit poke, input string tag);
    int n;
    int sp;
    sp = (d == 0) ? S0 : S1;
    @(negedge clk);
    start_i[d] = 1'b1;
    @(negedge clk);
    start_i[d] = 1'b0;
    if (d == 1 && mode[1] == 3) glitch = 1'b1;
    n = 0;
    while (done_o[d] !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      start_i[d] = (poke && n == 3);
      if (d == 1 && mode[1] == 3) glitch = ((n % (sp + 1)) != sp) && (n < 4 * (sp + 1));
    end
    glitch = 1'b0;
    chk({tag, "_latency"}, d, 32'(n), 32'(exp_lat));
  endtask

  task automatic expect_result(input int d, input string tag, input logic p,
                               input logic [6:0] mk, input logic [2:0] ec, input logic [1:0] ff);
    chk({tag, "_pass"}, d, 32'(pass_o[d]), 32'(p));
    chk({tag, "_mask"}, d, 32'(mask_o[d]), 32'(mk));
    chk({tag, "_err"}, d, 32'(err_o[d]), 32'(ec));
    chk({tag, "_first"}, d, 32'(first_o[d]), 32'(ff));
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    chk_en = 1'b0;
    glitch = 1'b0;
    rst = 1'b1;
    start_i[0] = 1'b0;
    start_i[1] = 1'b0;
    mode[0] = 0;
    mode[1] = 3;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    expect_result(0, "reset", 1'b0, 7'h00, 3'd0, 2'b00);
    chk("reset_ab", 0, 32'({a_o[0], b_o[0]}), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Ideal bank, start poked while busy has no effect
    run(0, 8, 1'b1, "ideal");
    expect_result(0, "ideal", 1'b1, 7'h00, 3'd0, 2'b00);
    chk("ideal_ab_hold", 0, 32'({a_o[0], b_o[0]}), 32'h3);

    // XOR stuck at 0, restarted straight from DONE
    mode[0] = 1;
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
    run(0, 4, 1'b0, "xor0");
    expect_result(0, "xor0", 1'b0, 7'h10, 3'd1, 2'b01);
`else
    run(0, 8, 1'b0, "xor0");
    expect_result(0, "xor0", 1'b0, 7'h10, 3'd2, 2'b01);
`endif

    // All outputs inverted
    mode[0] = 2;
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
    run(0, 2, 1'b0, "inv");
    expect_result(0, "inv", 1'b0, 7'h7F, 3'd1, 2'b00);
`else
    run(0, 8, 1'b0, "inv");
    expect_result(0, "inv", 1'b0, 7'h7F, 3'd4, 2'b00);
`endif

    // Reset during vector 2 APPLY aborts cleanly
    mode[0] = 0;
    @(negedge clk);
    start_i[0] = 1'b1;
    @(negedge clk);
    start_i[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_ab_before", 0, 32'({a_o[0], b_o[0]}), 32'h2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", 0, 32'(busy_o[0]), 0);
    chk("abort_done", 0, 32'(done_o[0]), 0);
    chk("abort_ab", 0, 32'({a_o[0], b_o[0]}), 0);
    expect_result(0, "abort", 1'b0, 7'h00, 3'd0, 2'b00);
    repeat (2) @(negedge clk);
    run(0, 8, 1'b0, "after_abort");
    expect_result(0, "after_abort", 1'b1, 7'h00, 3'd0, 2'b00);

    // Longer settle with z glitching to 0 whenever not in the check cycle
    run(1, 16, 1'b0, "glitch");
    expect_result(1, "glitch", 1'b1, 7'h00, 3'd0, 2'b00);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog for the whole run
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, limit reached");
    $fatal(1, "watchdog");
  end

endmodule
